// File: rtl/pe_out_collector_if.sv
// Interface bundling the parallel capture port and the serial drain port
// of pe_out_collector. The optional s_out_last signal exists only when
// CNT_LAST_EN is defined.
interface pe_out_collector_if #(
  parameter int PE_NUM     = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int WORD_W = 2 * DATA_WIDTH;

  logic                     p_in_v;
  logic [PE_NUM*WORD_W-1:0] p_in;
  logic                     p_in_rdy;
  logic                     s_out_v;
  logic                     s_out_rdy;
  logic [WORD_W-1:0]        s_out;
  logic                     overflow;
`ifdef CNT_LAST_EN
  logic                     s_out_last;
`endif

  // Collector side
  modport slave (
    input  p_in_v,
    input  p_in,
    input  s_out_rdy,
    output p_in_rdy,
    output s_out_v,
    output s_out,
    output overflow
`ifdef CNT_LAST_EN
    ,
    output s_out_last
`endif
  );

  // Producer / consumer side
  modport master (
    output p_in_v,
    output p_in,
    output s_out_rdy,
    input  p_in_rdy,
    input  s_out_v,
    input  s_out,
    input  overflow
`ifdef CNT_LAST_EN
    ,
    input  s_out_last
`endif
  );
endinterface

// File: rtl/pe_out_collector.sv
// pe_out_collector: captures one PE_NUM-lane result vector into a two-bank
// ping-pong buffer and drains it one word per cycle on a valid/ready port.
// Banks fill and drain in strict order, so the pair behaves as a 2-deep
// vector FIFO; all outputs are registered.
// Optional feature macro: CNT_LAST_EN (adds s_out_last and a 16-bit
// drained-vector counter visible through hierarchy).
module pe_out_collector #(
  parameter int PE_NUM     = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  pe_out_collector_if.slave  bus
);
  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PE_NUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] s_out_q, s_out_d;
  logic              s_out_v_q, s_out_v_d;
  logic              p_in_rdy_q, p_in_rdy_d;
  logic              overflow_q, overflow_d;
  logic              capture_s;
  logic              drop_s;
  logic              pop_s;
  logic              other_bank_s;
  logic [WORD_W-1:0] bank_q [2][PE_NUM];
`ifdef CNT_LAST_EN
  logic              last_q, last_d;
  logic [15:0]       vec_cnt_q, vec_cnt_d;
`endif

  // Next-state logic: capture/drop decisions, drain FSM and output words
  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    cnt_d        = cnt_q;
    s_out_d      = s_out_q;
    overflow_d   = overflow_q;
    other_bank_s = ~rd_bank_q;
`ifdef CNT_LAST_EN
    vec_cnt_d    = vec_cnt_q;
`endif

    // Occupancy is judged on registered state only, so a bank freed on
    // this edge cannot take a capture on the same edge.
    capture_s = bus.p_in_v && (full_q != 2'b11);
    drop_s    = bus.p_in_v && (full_q == 2'b11);
    pop_s     = s_out_v_q && bus.s_out_rdy;

    if (capture_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = ST_SEND;
          cnt_d   = {CNT_W{1'b0}};
          s_out_d = bank_q[rd_bank_q][0];
        end else begin
          s_out_d = {WORD_W{1'b0}};
        end
      end
      ST_SEND: begin
        if (pop_s) begin
          if (cnt_q == LAST_LANE) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = other_bank_s;
            cnt_d             = {CNT_W{1'b0}};
`ifdef CNT_LAST_EN
            vec_cnt_d         = vec_cnt_q + 16'd1;
`endif
            // Back-to-back drain only if the other bank was already full.
            if (full_q[other_bank_s]) begin
              s_out_d = bank_q[other_bank_s][0];
            end else begin
              state_d = ST_IDLE;
              s_out_d = {WORD_W{1'b0}};
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            s_out_d = bank_q[rd_bank_q][cnt_q + CNT_W'(1)];
          end
        end else begin
          s_out_d = s_out_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        s_out_d = {WORD_W{1'b0}};
      end
    endcase

    s_out_v_d  = (state_d == ST_SEND);
    p_in_rdy_d = ~(&full_d);
`ifdef CNT_LAST_EN
    last_d     = s_out_v_d && (cnt_d == LAST_LANE);
`endif
  end

  // Control state and registered outputs; bank storage is left untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      s_out_q    <= {WORD_W{1'b0}};
      s_out_v_q  <= 1'b0;
      p_in_rdy_q <= 1'b1;
      overflow_q <= 1'b0;
`ifdef CNT_LAST_EN
      last_q     <= 1'b0;
      vec_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      cnt_q      <= cnt_d;
      s_out_q    <= s_out_d;
      s_out_v_q  <= s_out_v_d;
      p_in_rdy_q <= p_in_rdy_d;
      overflow_q <= overflow_d;
`ifdef CNT_LAST_EN
      last_q     <= last_d;
      vec_cnt_q  <= vec_cnt_d;
`endif
    end
  end

  // Bank write: store all lanes of an accepted vector into the write bank
  always_ff @(posedge clk) begin
    if (capture_s) begin
      for (int i = 0; i < PE_NUM; i++) begin
        bank_q[wr_bank_q][i] <= bus.p_in[i*WORD_W +: WORD_W];
      end
    end
  end

  assign bus.p_in_rdy = p_in_rdy_q;
  assign bus.s_out_v  = s_out_v_q;
  assign bus.s_out    = s_out_q;
  assign bus.overflow = overflow_q;
`ifdef CNT_LAST_EN
  assign bus.s_out_last = last_q;
`endif
endmodule
